// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR generator family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lfsr_pkg;

    typedef enum logic [0:0] {
        LFSR_FIB    = 1'b0,
        LFSR_GALOIS = 1'b1
    } lfsr_mode_e;

    // Maximal-length feedback masks, bit i set = state[i] in feedback.
    // Index is the state width.
    localparam logic [31:0] LFSR_MAX_TAPS [3:32] = '{
        32'h0000_0006, 32'h0000_000C, 32'h0000_0014, 32'h0000_0030,
        32'h0000_0060, 32'h0000_00B8, 32'h0000_0110, 32'h0000_0240,
        32'h0000_0500, 32'h0000_0829, 32'h0000_100D, 32'h0000_2015,
        32'h0000_6000, 32'h0000_D008, 32'h0001_2000, 32'h0002_0400,
        32'h0004_0023, 32'h0009_0000, 32'h0014_0000, 32'h0030_0000,
        32'h0042_0000, 32'h00E1_0000, 32'h0120_0000, 32'h0200_0023,
        32'h0400_0013, 32'h0900_0000, 32'h1400_0000, 32'h2000_0029,
        32'h4800_0000, 32'h8020_0003
    };

    // Longest possible sequence for a given state width.
    function automatic logic [32:0] lfsr_period_max(input int unsigned width);
        return (33'd1 << width) - 33'd1;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR next-state, Fibonacci or Galois form.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to register the result.
// Ports: state (current LFSR state), next_state (state after one step).
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'hC,
    parameter lfsr_mode_e       MODE  = LFSR_FIB
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    generate
        if (MODE == LFSR_FIB) begin : g_fib
            // Shift up, parity of tapped bits enters at bit 0.
            always_comb begin
                next_state = {state[WIDTH-2:0], ^(state & TAPS)};
            end
        end else begin : g_galois
            // Shift up; when the top bit falls out, fold the polynomial back in.
            always_comb begin
                next_state = {state[WIDTH-2:0], 1'b0};
                if (state[WIDTH-1]) begin
                    next_state = next_state ^ {TAPS[WIDTH-2:0], 1'b1};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/lfsr_stream.sv
// LFSR word stream with seed load, all-zero lock-up recovery and period measurement.
// Latency: 1 cycle from accepted word to next state; all outputs registered.
// Backpressure: data_out and state hold while out_valid & ~out_ready.
// Ports: clk, reset (sync active-low), enable, load, seed_in, out_ready in;
//        out_valid, data_out, wrap, lockup, period_out out.
module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'hC,
    parameter logic [WIDTH-1:0] SEED  = 4'hF,
    parameter lfsr_mode_e       MODE  = LFSR_FIB
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             wrap,
    output logic             lockup,
    output logic [WIDTH-1:0] period_out
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] ref_seed;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] load_val;
    logic             advance;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_next (
        .state      (state),
        .next_state (step)
    );

    assign advance  = enable & out_valid & out_ready;
    // A zero seed would lock the register forever; substitute the reset seed.
    assign load_val = (seed_in == '0) ? SEED : seed_in;
    assign data_out = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= SEED;
            ref_seed   <= SEED;
            cnt        <= '0;
            period_out <= '0;
            out_valid  <= 1'b0;
            wrap       <= 1'b0;
            lockup     <= 1'b0;
        end else begin
            out_valid <= enable & ~load;
            wrap      <= 1'b0;
            if (load) begin
                state    <= load_val;
                ref_seed <= load_val;
                cnt      <= '0;
                if (seed_in == '0) begin
                    lockup <= 1'b1;
                end
            end else if (advance) begin
                if (state == '0) begin
                    // Only reachable through an upset; restart from the reset seed.
                    state  <= SEED;
                    cnt    <= '0;
                    lockup <= 1'b1;
                end else begin
                    state <= step;
                    if (step == ref_seed) begin
                        wrap       <= 1'b1;
                        period_out <= cnt + 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_stream.sv
module tb_lfsr_stream;

    typedef struct {
        logic [15:0] dat;
        logic        wrp;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        load;
    logic [3:0]  seed_in;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  data_out;
    logic        wrap;
    logic        lockup;
    logic [3:0]  period_out;

    logic        en_g;
    logic        g_valid;
    logic [3:0]  g_data;
    logic        g_wrap;
    logic        g_lockup;
    logic [3:0]  g_period;

    logic        en_w;
    logic        w_valid;
    logic [15:0] w_data;
    logic        w_wrap;
    logic        w_lockup;
    logic [15:0] w_period;

    logic        one;
    logic        zero;
    logic [3:0]  zero4;
    logic [15:0] zero16;

    exp_t exp_q[$];
    exp_t g_q[$];

    int n_chk;
    int n_pass;

    lfsr_stream dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .seed_in    (seed_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .data_out   (data_out),
        .wrap       (wrap),
        .lockup     (lockup),
        .period_out (period_out)
    );

    lfsr_stream #(
        .MODE (lfsr_pkg::LFSR_GALOIS)
    ) dut_g (
        .clk        (clk),
        .reset      (reset),
        .enable     (en_g),
        .load       (zero),
        .seed_in    (zero4),
        .out_ready  (one),
        .out_valid  (g_valid),
        .data_out   (g_data),
        .wrap       (g_wrap),
        .lockup     (g_lockup),
        .period_out (g_period)
    );

    lfsr_stream #(
        .WIDTH (16),
        .TAPS  (16'hB400),
        .SEED  (16'h0001)
    ) dut_w (
        .clk        (clk),
        .reset      (reset),
        .enable     (en_w),
        .load       (zero),
        .seed_in    (zero16),
        .out_ready  (one),
        .out_valid  (w_valid),
        .data_out   (w_data),
        .wrap       (w_wrap),
        .lockup     (w_lockup),
        .period_out (w_period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Compare any word the consumer takes this cycle, then step one clock.
    task automatic cyc();
        exp_t e;
        if (reset && enable && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {28'd0, data_out}, 32'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("data", {28'd0, data_out}, {16'd0, e.dat});
                chk("wrap", {31'd0, wrap}, {31'd0, e.wrp});
            end
        end
        if (reset && en_g && g_valid) begin
            if (g_q.size() == 0) begin
                chk("g_unexpected_word", {28'd0, g_data}, 32'hDEAD);
            end else begin
                e = g_q.pop_front();
                chk("g_data", {28'd0, g_data}, {16'd0, e.dat});
                chk("g_wrap", {31'd0, g_wrap}, {31'd0, e.wrp});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic w);
        exp_t e;
        e.dat = d;
        e.wrp = w;
        exp_q.push_back(e);
    endtask

    task automatic push_g(input logic [15:0] d, input logic w);
        exp_t e;
        e.dat = d;
        e.wrp = w;
        g_q.push_back(e);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || g_q.size() != 0) && b < 200) begin
            cyc();
            b++;
        end
        chk("drain_left", exp_q.size() + g_q.size(), 0);
    endtask

    initial begin
        logic [3:0] fib_seq [0:15];
        logic [3:0] fib_9   [0:15];
        logic [3:0] gal_seq [0:15];
        int nw;

        fib_seq = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                    4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};
        fib_9   = '{4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7,
                    4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9};
        gal_seq = '{4'hF, 4'h7, 4'hE, 4'h5, 4'hA, 4'hD, 4'h3, 4'h6,
                    4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h9, 4'hB, 4'hF};

        n_chk = 0;
        n_pass = 0;
        one = 1'b1;
        zero = 1'b0;
        zero4 = '0;
        zero16 = '0;
        reset = 1'b0;
        enable = 1'b0;
        load = 1'b1;
        seed_in = 4'h5;
        out_ready = 1'b0;
        en_g = 1'b0;
        en_w = 1'b0;

        // Reset state (load asserted during reset must be ignored).
        repeat (3) cyc();
        chk("rst_data", {28'd0, data_out}, 32'hF);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_wrap", {31'd0, wrap}, 32'd0);
        chk("rst_lockup", {31'd0, lockup}, 32'd0);
        chk("rst_period", {28'd0, period_out}, 32'd0);

        // Free-running default sequence with wrap back to F.
        load = 1'b0;
        seed_in = 4'h0;
        reset = 1'b1;
        enable = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) push({12'd0, fib_seq[i]}, i == 15);
        drain();
        chk("t1_period", {28'd0, period_out}, 32'd15);

        // Backpressure while data_out = C.
        push(16'hE, 1'b0);
        drain();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2_hold_data", {28'd0, data_out}, 32'hC);
            chk("t2_hold_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        push(16'hC, 1'b0);
        push(16'h8, 1'b0);
        drain();

        // Zero seed load: SEED substituted, lockup latched.
        push(16'h1, 1'b0);
        load = 1'b1;
        seed_in = 4'h0;
        cyc();
        load = 1'b0;
        chk("t3_data", {28'd0, data_out}, 32'hF);
        chk("t3_valid", {31'd0, out_valid}, 32'd0);
        chk("t3_lockup", {31'd0, lockup}, 32'd1);
        push(16'hF, 1'b0);
        push(16'hE, 1'b0);
        push(16'hC, 1'b0);
        drain();
        chk("t3_lockup_sticky", {31'd0, lockup}, 32'd1);

        // Load 9 concurrently with a handshake: no step, new reference seed.
        push(16'h8, 1'b0);
        load = 1'b1;
        seed_in = 4'h9;
        cyc();
        load = 1'b0;
        chk("t4_data", {28'd0, data_out}, 32'h9);
        chk("t4_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 16; i++) push({12'd0, fib_9[i]}, i == 15);
        drain();
        chk("t4_period", {28'd0, period_out}, 32'd15);
        chk("t4_lockup", {31'd0, lockup}, 32'd1);

        // Generator disabled: state holds, valid drops.
        enable = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("en0_valid", {31'd0, out_valid}, 32'd0);
        chk("en0_data", {28'd0, data_out}, 32'h3);
        enable = 1'b1;
        push(16'h3, 1'b0);
        push(16'h6, 1'b0);
        drain();

        // Galois form.
        enable = 1'b0;
        cyc();
        en_g = 1'b1;
        for (int i = 0; i < 16; i++) push_g({12'd0, gal_seq[i]}, i == 15);
        drain();
        chk("t5_period", {28'd0, g_period}, 32'd15);

        // 16-bit maximal period: exactly one wrap in 65535 advances.
        en_g = 1'b0;
        en_w = 1'b1;
        cyc();
        nw = 0;
        for (int i = 0; i < 65535; i++) begin
            cyc();
            if (w_wrap) nw++;
        end
        chk("w_wrap_count", nw, 1);
        chk("w_wrap_now", {31'd0, w_wrap}, 32'd1);
        chk("w_period", {16'd0, w_period}, 32'd65535);
        chk("w_data", {16'd0, w_data}, 32'h0001);

        // Reset mid-run overrides a simultaneous load.
        en_w = 1'b0;
        enable = 1'b1;
        cyc();
        push(16'hD, 1'b0);
        push(16'hA, 1'b0);
        drain();
        reset = 1'b0;
        load = 1'b1;
        seed_in = 4'h6;
        cyc();
        chk("t6_data", {28'd0, data_out}, 32'hF);
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_period", {28'd0, period_out}, 32'd0);
        chk("t6_lockup", {31'd0, lockup}, 32'd0);
        chk("t6_wrap", {31'd0, wrap}, 32'd0);
        chk("t6_g_period", {28'd0, g_period}, 32'd0);
        reset = 1'b1;
        load = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
